// File: rtl/encoder_8to3.sv
// rtl/encoder_8to3.sv - registered 8-to-3 priority encoder with enable and valid flag
// Optional multi-hot error output: define ENCODER_8TO3_MULTI_HOT_ERR_EN.
module encoder_8to3 #(
  parameter int PRIORITY_MSB = 1
) (
  input  logic       en,
  input  logic [7:0] in,
  output logic [2:0] y,
  output logic       v,
`ifdef ENCODER_8TO3_MULTI_HOT_ERR_EN
  output logic       err,
`endif
  input  logic       clk,
  input  logic       rst_n
);

  logic [2:0] y_d, y_q;
  logic       v_d, v_q;

  always_comb begin
    v_d = en & (|in);
    y_d = 3'd0;
    if (v_d) begin
      // Later loop iterations overwrite earlier ones, so scan order sets priority.
      if (PRIORITY_MSB != 0) begin
        for (int i = 0; i < 8; i++) begin
          if (in[i]) y_d = 3'(i);
        end
      end else begin
        for (int i = 7; i >= 0; i--) begin
          if (in[i]) y_d = 3'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q <= 3'd0;
      v_q <= 1'b0;
    end else begin
      y_q <= y_d;
      v_q <= v_d;
    end
  end

  assign y = y_q;
  assign v = v_q;

`ifdef ENCODER_8TO3_MULTI_HOT_ERR_EN
  logic err_d, err_q;

  // Clearing the lowest set bit leaves something only if two or more were set.
  always_comb begin
    err_d = en & (|(in & (in - 8'd1)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_encoder_8to3.sv
// tb/tb_encoder_8to3.sv - scoreboard bench for encoder_8to3 (MSB and LSB priority instances)
module tb_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] in;
  logic [2:0] y_m, y_l;
  logic       v_m, v_l;
  logic       err_m, err_l;

  int errors = 0;
  int checks = 0;

  logic [9:0] sb[$];
  logic [9:0] exp_w;
  logic [9:0] obs_w;

  always #5 clk = ~clk;

  encoder_8to3 #(.PRIORITY_MSB(1)) dut_msb (
    .en(en), .in(in), .y(y_m), .v(v_m),
`ifdef ENCODER_8TO3_MULTI_HOT_ERR_EN
    .err(err_m),
`endif
    .clk(clk), .rst_n(rst_n)
  );

  encoder_8to3 #(.PRIORITY_MSB(0)) dut_lsb (
    .en(en), .in(in), .y(y_l), .v(v_l),
`ifdef ENCODER_8TO3_MULTI_HOT_ERR_EN
    .err(err_l),
`endif
    .clk(clk), .rst_n(rst_n)
  );

`ifndef ENCODER_8TO3_MULTI_HOT_ERR_EN
  assign err_m = 1'b0;
  assign err_l = 1'b0;
`endif

  assign obs_w = {y_m, v_m, y_l, v_l, err_m, err_l};

  // Packed expectation: {y_msb, v, y_lsb, v, err, err}
  function automatic logic [9:0] model(input logic r, input logic e, input logic [7:0] d);
    logic [2:0] hi, lo;
    logic       vv, ee;
    int         k;
    hi = 3'd0;
    lo = 3'd0;
    if (!r) return 10'd0;
    vv = e && (d != 8'h00);
    if (vv) begin
      k = 7;
      while (!d[k]) k--;
      hi = 3'(k);
      k = 0;
      while (!d[k]) k++;
      lo = 3'(k);
    end
`ifdef ENCODER_8TO3_MULTI_HOT_ERR_EN
    ee = e && ($countones(d) > 1);
`else
    ee = 1'b0;
`endif
    return {hi, vv, lo, vv, ee, ee};
  endfunction

  task automatic step(input logic r, input logic e, input logic [7:0] d);
    rst_n = r;
    en    = e;
    in    = d;
    sb.push_back(model(r, e, d));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      step(i == 2, 1'b1, 8'hFF);
      checks++;
      exp_w = sb.pop_front();
      if (obs_w !== exp_w) begin
        errors++;
        $display("FAIL reset[%0d]: got ym=%0d v=%0b yl=%0d err=%0b, required %h", i, y_m, v_m, y_l, err_m, exp_w);
      end
    end
    checks++;
    if (y_m !== 3'd7 || v_m !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got y=%0d v=%0b, required y=7 v=1", y_m, v_m);
    end
  endtask

  task automatic test_disable;
    logic [7:0] pat [2];
    pat[0] = 8'h00;
    pat[1] = 8'h10;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, pat[i]);
      checks++;
      exp_w = sb.pop_front();
      if (obs_w !== exp_w) begin
        errors++;
        $display("FAIL disable[%h]: got %h, required %h", pat[i], obs_w, exp_w);
      end
    end
  endtask

  task automatic test_one_hot;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 8'(1 << i));
      checks++;
      exp_w = sb.pop_front();
      if (obs_w !== exp_w || y_m !== 3'(i) || y_l !== 3'(i)) begin
        errors++;
        $display("FAIL one_hot[%0d]: got %h, required %h", i, obs_w, exp_w);
      end
    end
  endtask

  task automatic test_zero;
    step(1'b1, 1'b1, 8'h00);
    checks++;
    exp_w = sb.pop_front();
    if (obs_w !== exp_w || v_m !== 1'b0) begin
      errors++;
      $display("FAIL zero_enabled: got %h, required %h", obs_w, exp_w);
    end
    step(1'b1, 1'b1, 8'h01);
    checks++;
    exp_w = sb.pop_front();
    if (obs_w !== exp_w || v_m !== 1'b1 || y_m !== 3'd0) begin
      errors++;
      $display("FAIL bit0_request: got %h, required %h", obs_w, exp_w);
    end
  endtask

  task automatic test_priority;
    step(1'b1, 1'b1, 8'b0101_0010);
    checks++;
    exp_w = sb.pop_front();
    if (obs_w !== exp_w || y_m !== 3'd6 || y_l !== 3'd1) begin
      errors++;
      $display("FAIL priority_52: got ym=%0d yl=%0d v=%0b err=%0b, required %h", y_m, y_l, v_m, err_m, exp_w);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 8'($urandom_range(1, 255)));
      checks++;
      exp_w = sb.pop_front();
      if (obs_w !== exp_w) begin
        errors++;
        $display("FAIL priority_rand[%0d] in=%h: got %h, required %h", i, in, obs_w, exp_w);
      end
    end
  endtask

  task automatic test_mid_stream;
    int vlow;
    vlow = 0;
    for (int i = 0; i < 8; i++) begin
      step(i != 3, i != 5, 8'(1 << i));
      checks++;
      exp_w = sb.pop_front();
      if (obs_w !== exp_w) begin
        errors++;
        $display("FAIL mid_stream[%0d]: got %h, required %h", i, obs_w, exp_w);
      end
      if (i >= 4 && !v_m) vlow++;
    end
    checks++;
    if (vlow !== 1) begin
      errors++;
      $display("FAIL en_drop_width: got %0d low cycles, required 1", vlow);
    end
  endtask

  task automatic test_back_to_back;
    logic e;
    for (int i = 0; i < 30; i++) begin
      e = ($urandom_range(0, 3) != 0);
      step(1'b1, e, 8'($urandom_range(0, 255)));
      checks++;
      exp_w = sb.pop_front();
      if (obs_w !== exp_w) begin
        errors++;
        $display("FAIL back_to_back[%0d] en=%0b in=%h: got %h, required %h", i, en, in, obs_w, exp_w);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    in    = 8'h00;
    @(negedge clk);
    test_reset();
    test_disable();
    test_one_hot();
    test_zero();
    test_priority();
    test_mid_stream();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
